// File: rtl/fire_fifo_param.sv
// fire_fifo_param -- parameterised first-word-fall-through FIFO for neuron fire tags.
//
// Parameters:
//   TAG_W     width of each fire tag (neuron index), >= 1
//   DEPTH     number of entries, power of two, >= 2
//   AF_THRESH occupancy at which almost_full asserts, 1..DEPTH
//
// Ports:
//   clk          single clock, rising edge
//   asyn_reset   synchronous active-high reset (the name is historical)
//   enq / in_tag push in_tag this cycle
//   deq          pop the head entry this cycle
//   flush        discard every entry; enq/deq in the same cycle are dropped
//   clr_err      clear the sticky overflow/underflow flags
//   out_tag      head entry (combinational), all-zero when empty
//   full, empty, almost_full, count  occupancy status, decoded from registered count
//   overflow     sticky: an enq was dropped because the FIFO was full
//   underflow    sticky: a deq was ignored because the FIFO was empty
module fire_fifo_param #(
    parameter int TAG_W     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             enq,
    input  logic             deq,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    input  logic             clr_err,
    output logic [TAG_W-1:0] out_tag,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic do_enq;
    logic do_deq;
    logic ovf_evt;
    logic unf_evt;

    // Status is decoded from the registered count only, so no input reaches
    // these outputs combinationally.
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AF_THRESH));
    assign out_tag     = empty ? '0 : mem[rd_ptr];

    // A full FIFO still accepts an enq when a deq frees the head slot in the
    // same cycle. An enq on an empty FIFO is accepted even if the deq is not.
    assign do_deq  = deq && !empty && !flush;
    assign do_enq  = enq && (!full || deq) && !flush;
    assign ovf_evt = enq && full && !deq && !flush;
    assign unf_evt = deq && empty && !flush;

    // Storage carries no reset; out_tag masks it while empty.
    always_ff @(posedge clk) begin
        if (!asyn_reset && do_enq)
            mem[wr_ptr] <= in_tag;
    end

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // increment wraps DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a new event in the same cycle as clr_err wins.
    // Flush never raises an event (its enq/deq are discarded) but does not
    // block clr_err either.
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || ovf_evt;
            underflow <= (underflow && !clr_err) || unf_evt;
        end
    end

endmodule

// File: tb/tb_fire_fifo_param.sv
// Self-checking bench for fire_fifo_param (DEPTH=4, TAG_W=8, AF_THRESH=3).
// A queue-based reference model tracks expected contents; dequeued data is
// popped from the scoreboard and compared against out_tag before the edge.
module tb_fire_fifo_param;

    localparam int TAG_W = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             asyn_reset = 1'b0;
    logic             enq = 1'b0;
    logic             deq = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             clr_err = 1'b0;
    logic [TAG_W-1:0] out_tag;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    fire_fifo_param #(.TAG_W(TAG_W), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk(clk), .asyn_reset(asyn_reset), .enq(enq), .deq(deq),
        .in_tag(in_tag), .flush(flush), .clr_err(clr_err),
        .out_tag(out_tag), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [TAG_W-1:0] sb [$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle from the negedge, update the model, check after the edge.
    task automatic step(input bit r, input bit e, input bit d,
                        input logic [TAG_W-1:0] t, input bit f, input bit c);
        logic [TAG_W-1:0] exp_head;
        bit ovf_e;
        bit unf_e;
        asyn_reset = r; enq = e; deq = d; in_tag = t; flush = f; clr_err = c;
        if (r) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (f) begin
            sb.delete();
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            ovf_e = e && (sb.size() == DEPTH) && !d;
            unf_e = d && (sb.size() == 0);
            if (d && sb.size() > 0) begin
                exp_head = sb.pop_front();
                chk("deq_data", out_tag, exp_head);
            end
            if (e && sb.size() < DEPTH)
                sb.push_back(t);
            m_ovf = (m_ovf && !c) || ovf_e;
            m_unf = (m_unf && !c) || unf_e;
        end
        @(posedge clk);
        @(negedge clk);
        asyn_reset = 1'b0; enq = 1'b0; deq = 1'b0; flush = 1'b0; clr_err = 1'b0;
        chk("count", count, sb.size());
        chk("empty", empty, sb.size() == 0);
        chk("full", full, sb.size() == DEPTH);
        chk("almost_full", almost_full, sb.size() >= AF);
        chk("head", out_tag, sb.size() > 0 ? sb[0] : 8'h00);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    initial begin
        @(negedge clk);
        // reset
        step(1, 0, 0, 8'h00, 0, 0);
        // basic enq/deq, FWFT latency
        step(0, 1, 0, 8'h11, 0, 0);
        step(0, 1, 0, 8'h22, 0, 0);
        step(0, 0, 1, 8'h00, 0, 0);
        step(0, 0, 1, 8'h00, 0, 0);
        // fill, overflow, drain order
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hA0 + 8'(i), 0, 0);
        step(0, 1, 0, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 1);
        // simultaneous enq+deq while full
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hB0 + 8'(i), 0, 0);
        step(0, 1, 1, 8'h55, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 0, 0);
        // wrap-around with alternating enq/deq
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step(0, 1, 0, 8'hC0 + 8'(i), 0, 0);
            else            step(0, 0, 1, 8'h00, 0, 0);
        end
        // underflow with simultaneous enq, clear, clear racing a new event
        step(0, 1, 1, 8'h33, 0, 0);
        step(0, 0, 0, 8'h00, 0, 1);
        step(0, 0, 1, 8'h00, 0, 0);
        step(0, 0, 1, 8'h00, 0, 1);
        // flush at count 3 with enq+deq; underflow stays set
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hD0 + 8'(i), 0, 0);
        step(0, 1, 1, 8'hEE, 1, 0);
        // reset at count 2 with overflow set
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'hE0 + 8'(i), 0, 0);
        step(0, 0, 1, 8'h00, 0, 0);
        step(0, 0, 1, 8'h00, 0, 0);
        step(1, 1, 1, 8'h99, 0, 0);
        // random traffic
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 8'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fire_fifo_param.md
FIRE_FIFO_PARAM -- requirements
Module: fire_fifo_param

Interface
REQ-001 Parameter: TAG_W, default 8, width of each fire tag (neuron index); SHALL be >= 1.
REQ-002 Parameter: DEPTH, default 16, number of entries; SHALL be a power of two and >= 2.
REQ-003 Parameter: AF_THRESH, default DEPTH-2, occupancy at which almost_full asserts; SHALL satisfy 1 <= AF_THRESH <= DEPTH.
REQ-004 Derived: CNT_W = log2(DEPTH)+1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 asyn_reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 enq  input  1  push in_tag this cycle.
REQ-008 deq  input  1  pop the head entry this cycle.
REQ-009 in_tag  input  TAG_W  tag to push.
REQ-010 flush  input  1  discard all entries.
REQ-011 clr_err  input  1  clear the sticky error flags.
REQ-012 out_tag  output  TAG_W  head entry, first-word-fall-through.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 almost_full  output  1  count >= AF_THRESH.
REQ-016 count  output  CNT_W  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  sticky; an enq was dropped.
REQ-018 underflow  output  1  sticky; a deq was ignored.

Function
REQ-019 Storage: circular buffer of DEPTH x TAG_W, write pointer, read pointer, occupancy counter; pointers wrap DEPTH-1 -> 0.
REQ-020 Priority per edge: asyn_reset > flush > enq/deq; clr_err is independent of flush.
REQ-021 Accepted enq: writes in_tag at wr_ptr; wr_ptr+1; count+1.
REQ-022 Accepted deq: rd_ptr+1; count-1.
REQ-023 enq with deq, 0 < count < DEPTH: both accepted; count unchanged.
REQ-024 enq with full and no deq: enq dropped; storage, pointers and count unchanged; overflow set next cycle.
REQ-025 enq with deq while full: both accepted; count stays DEPTH; overflow not set.
REQ-026 deq with empty: deq ignored; underflow set next cycle; a simultaneous enq is still accepted (count 0 -> 1).
REQ-027 Latency: an entry written at edge N SHALL appear on out_tag after edge N when it is the head; no additional cycle.
REQ-028 out_tag: combinational read of mem[rd_ptr] when count > 0; SHALL be all-zero when empty.
REQ-029 full, empty, almost_full: combinational decode of the registered count only; no input-to-output paths.
REQ-030 flush: rd_ptr, wr_ptr and count go to 0; any enq/deq in the same cycle is discarded; overflow/underflow unaffected unless clr_err.
REQ-031 clr_err: both sticky flags clear; a new error event in the same cycle SHALL win, flag = 1.
REQ-032 Storage contents need not be reset; observable outputs never expose stale data (REQ-028).

Reset
REQ-033 With asyn_reset high at an edge: pointers = 0, count = 0, overflow = 0, underflow = 0; all other inputs ignored that cycle.
REQ-034 Values after reset: empty=1, full=0, almost_full=0, count=0, out_tag=0, overflow=0, underflow=0.
REQ-035 Reset mid-operation (any occupancy) SHALL yield the REQ-034 values after the next edge.

Verification (DEPTH=4, TAG_W=8, AF_THRESH=3)
REQ-036 Reset, then enq 0x11, 0x22 on consecutive cycles -> count=2, out_tag=0x11, empty=0; deq -> out_tag=0x22; deq -> empty=1, out_tag=0x00.
REQ-037 Enq 0xA0..0xA3 -> full=1 and almost_full=1 from count 3; enq 0xFF alone -> count=4, overflow=1, 0xFF never appears on out_tag; drain order is A0, A1, A2, A3.
REQ-038 Full with simultaneous enq 0x55 and deq -> count=4, overflow=0, 0x55 appears last; wrap-around: 10 alternating enq/deq cycles show FIFO order preserved.
REQ-039 Empty with deq plus enq 0x33 -> underflow=1, count=1, out_tag=0x33; clr_err alone -> underflow=0; clr_err together with deq on empty -> underflow=1.
REQ-040 Count=3 with flush, enq and deq together -> count=0, empty=1, sticky flags unchanged; asyn_reset at count=2 with overflow=1 -> all REQ-034 values.
